// File: rtl/param_bus_arbiter.sv
// Round-robin arbiter for the synth-controller parameter write bus.
// Each granted write holds data_ready for HOLD_CYC cycles, then keeps the strobe low for GAP_CYC cycles before the next write.
module param_bus_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int BANK_W    = 3,
  parameter int ADR_W     = 7,
  parameter int DATA_W    = 8,
  parameter int NUM_BANKS = 6,
  parameter int HOLD_CYC  = 5,
  parameter int GAP_CYC   = 2
) (
  input  logic                      reg_clk,
  input  logic                      reset_reg_N,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*BANK_W-1:0] req_bank,
  input  logic [NUM_REQ*ADR_W-1:0]  req_adr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        err,
  output logic [BANK_W-1:0]         bank_adr,
  output logic [ADR_W-1:0]          reg_adr,
  output logic [DATA_W-1:0]         out_data,
  output logic                      data_ready,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(HOLD_CYC + GAP_CYC + 1);

  typedef enum logic [2:0] {IDLE, LATCH, STROBE, GAP, REJECT} state_t;

  state_t             state;
  state_t             next_state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   pick;
  logic               pick_valid;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] win_onehot;
  logic [BANK_W-1:0]  sel_bank;
  logic               win_req;
  logic               bank_bad;

  assign sel_bank   = req_bank[int'(winner)*BANK_W +: BANK_W];
  assign win_req    = req[winner];
  assign bank_bad   = {1'b0, sel_bank} >= (BANK_W+1)'(NUM_BANKS);
  assign win_onehot = NUM_REQ'(1) << winner;
  assign next_ptr   = (int'(winner) == NUM_REQ-1) ? '0 : winner + 1'b1;

  // Scanned from the far end so the requester closest to ptr overwrites the rest.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = ptr;
    pick_valid = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        pick       = PTR_W'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) state <= IDLE;
    else              state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_valid) next_state = LATCH;
      LATCH: begin
        if (!win_req)      next_state = IDLE;
        else if (bank_bad) next_state = REJECT;
        else               next_state = STROBE;
      end
      STROBE:  if (cnt == '0) next_state = GAP;
      GAP:     if (cnt == '0) next_state = IDLE;
      REJECT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The bus is loaded only for writes that will strobe, so rejected or withdrawn requests never reach the decoder.
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      ptr      <= '0;
      winner   <= '0;
      cnt      <= '0;
      bank_adr <= '0;
      reg_adr  <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: if (pick_valid) winner <= pick;
        LATCH: begin
          if (win_req && !bank_bad) begin
            bank_adr <= sel_bank;
            reg_adr  <= req_adr[int'(winner)*ADR_W +: ADR_W];
            out_data <= req_data[int'(winner)*DATA_W +: DATA_W];
            cnt      <= CNT_W'(HOLD_CYC - 1);
          end
        end
        STROBE: begin
          if (cnt == '0) cnt <= CNT_W'(GAP_CYC - 1);
          else           cnt <= cnt - 1'b1;
        end
        GAP: begin
          if (cnt == '0) begin
            bank_adr <= '0;
            reg_adr  <= '0;
            out_data <= '0;
            ptr      <= next_ptr;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        REJECT: ptr <= next_ptr;
        default: ;
      endcase
    end
  end

  always_comb begin
    grant      = '0;
    ack        = '0;
    err        = '0;
    data_ready = 1'b0;
    busy       = (state != IDLE);
    case (state)
      LATCH:  grant = win_onehot;
      STROBE: begin
        grant      = win_onehot;
        data_ready = 1'b1;
      end
      GAP:    if (cnt == CNT_W'(GAP_CYC - 1)) ack = win_onehot;
      REJECT: err = win_onehot;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_param_bus_arbiter.sv
// Directed self-checking bench for param_bus_arbiter using the default parameters.
module tb_param_bus_arbiter;

  logic        reg_clk;
  logic        reset_reg_N;
  logic [1:0]  req;
  logic [5:0]  req_bank;
  logic [13:0] req_adr;
  logic [15:0] req_data;
  logic [1:0]  grant;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [2:0]  bank_adr;
  logic [6:0]  reg_adr;
  logic [7:0]  out_data;
  logic        data_ready;
  logic        busy;

  int checks;
  int failures;

  param_bus_arbiter dut (
    .reg_clk     (reg_clk),
    .reset_reg_N (reset_reg_N),
    .req         (req),
    .req_bank    (req_bank),
    .req_adr     (req_adr),
    .req_data    (req_data),
    .grant       (grant),
    .ack         (ack),
    .err         (err),
    .bank_adr    (bank_adr),
    .reg_adr     (reg_adr),
    .out_data    (out_data),
    .data_ready  (data_ready),
    .busy        (busy)
  );

  initial reg_clk = 1'b0;
  always #5 reg_clk = ~reg_clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int idx, input logic on, input logic [2:0] bank,
                                input logic [6:0] adr, input logic [7:0] data);
    req[idx]            = on;
    req_bank[idx*3 +: 3] = bank;
    req_adr[idx*7 +: 7]  = adr;
    req_data[idx*8 +: 8] = data;
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge reg_clk);
      #1;
    end
  endtask

  task automatic reset_pulse();
    reset_reg_N = 1'b0;
    tick(2);
    reset_reg_N = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_reg_N = 1'b0;
    req = '0;
    req_bank = '0;
    req_adr = '0;
    req_data = '0;
    tick(2);
    check_output("rst_grant", grant, 0);
    check_output("rst_ack_err", {ack, err}, 0);
    check_output("rst_ready_busy", {data_ready, busy}, 0);
    check_output("rst_bus", {bank_adr, reg_adr, out_data}, 0);
    reset_reg_N = 1'b1;
    tick(1);

    $display("[TB] single request");
    apply_stimulus(0, 1'b1, 3'd2, 7'h11, 8'h5A);
    tick(1);
    check_output("single_grant", grant, 2'b01);
    check_output("single_latch_ready", data_ready, 0);
    for (int c = 2; c <= 6; c++) begin
      tick(1);
      check_output("single_strobe_ready", data_ready, 1);
      check_output("single_strobe_bus", {bank_adr, reg_adr, out_data}, {3'd2, 7'h11, 8'h5A});
      check_output("single_strobe_ack", ack, 0);
    end
    tick(1);
    check_output("single_ack", ack, 2'b01);
    check_output("single_gap_grant", grant, 0);
    check_output("single_gap_ready", data_ready, 0);
    req[0] = 1'b0;
    tick(1);
    check_output("single_ack_once", ack, 0);
    check_output("single_gap_bus_hold", bank_adr, 3'd2);
    check_output("single_gap_busy", busy, 1);
    tick(1);
    check_output("single_idle_busy", busy, 0);
    check_output("single_idle_bus", {bank_adr, reg_adr, out_data}, 0);

    $display("[TB] simultaneous requests");
    reset_pulse();
    apply_stimulus(0, 1'b1, 3'd1, 7'h22, 8'hA1);
    apply_stimulus(1, 1'b1, 3'd3, 7'h33, 8'hB2);
    for (int g = 0; g < 4; g++) begin
      tick(1);
      check_output("rr_grant", grant, (g % 2 == 0) ? 2'b01 : 2'b10);
      check_output("rr_latch_ready", data_ready, 0);
      tick(1);
      check_output("rr_ready", data_ready, 1);
      check_output("rr_data", out_data, (g % 2 == 0) ? 8'hA1 : 8'hB2);
      check_output("rr_bank", bank_adr, (g % 2 == 0) ? 3'd1 : 3'd3);
      tick(5);
      check_output("rr_ack", ack, (g % 2 == 0) ? 2'b01 : 2'b10);
      check_output("rr_gap1_ready", data_ready, 0);
      if (g == 3) req = '0;
      tick(1);
      check_output("rr_gap2_ready", data_ready, 0);
      tick(1);
      check_output("rr_idle_busy", busy, 0);
    end

    $display("[TB] invalid bank");
    apply_stimulus(1, 1'b1, 3'd6, 7'h44, 8'h77);
    tick(1);
    check_output("inv1_grant", grant, 2'b10);
    tick(1);
    check_output("inv1_err", err, 2'b10);
    check_output("inv1_grant_drop", grant, 0);
    check_output("inv1_no_ack_ready", {ack, data_ready}, 0);
    check_output("inv1_bus", {bank_adr, reg_adr, out_data}, 0);
    req[1] = 1'b0;
    tick(1);
    check_output("inv1_idle", {err, busy}, 0);
    apply_stimulus(0, 1'b1, 3'd7, 7'h45, 8'h78);
    tick(1);
    check_output("inv0_grant", grant, 2'b01);
    tick(1);
    check_output("inv0_err", err, 2'b01);
    check_output("inv0_ready", data_ready, 0);
    req[0] = 1'b0;
    tick(1);

    $display("[TB] reset mid-strobe");
    apply_stimulus(0, 1'b1, 3'd0, 7'h01, 8'h02);
    apply_stimulus(1, 1'b1, 3'd4, 7'h55, 8'hC3);
    tick(1);
    check_output("ptr_adv_grant", grant, 2'b10);
    tick(3);
    check_output("mid_ready_before", data_ready, 1);
    check_output("mid_data_before", out_data, 8'hC3);
    #1 reset_reg_N = 1'b0;
    #1;
    check_output("mid_ready_async", data_ready, 0);
    check_output("mid_grant_async", grant, 0);
    check_output("mid_bus_async", {bank_adr, reg_adr, out_data}, 0);
    check_output("mid_busy_async", busy, 0);
    tick(1);
    check_output("mid_no_ack", ack, 0);
    req[0] = 1'b0;
    reset_reg_N = 1'b1;
    tick(1);
    check_output("reserve_grant", grant, 2'b10);
    tick(1);
    check_output("reserve_data", out_data, 8'hC3);
    tick(5);
    check_output("reserve_ack", ack, 2'b10);
    req[1] = 1'b0;
    tick(2);

    $display("[TB] withdrawn request and back-to-back");
    apply_stimulus(0, 1'b1, 3'd5, 7'h66, 8'h3C);
    tick(1);
    check_output("wd_grant", grant, 2'b01);
    req[0] = 1'b0;
    tick(1);
    check_output("wd_outputs", {grant, ack, err, data_ready, busy}, 0);
    check_output("wd_bus", {bank_adr, reg_adr, out_data}, 0);
    apply_stimulus(0, 1'b1, 3'd5, 7'h66, 8'h3C);
    apply_stimulus(1, 1'b1, 3'd2, 7'h12, 8'h34);
    tick(1);
    check_output("wd_ptr_kept_grant", grant, 2'b01);
    req[1] = 1'b0;
    tick(1);
    check_output("b2b_first_data", {bank_adr, out_data}, {3'd5, 8'h3C});
    tick(5);
    check_output("b2b_first_ack", ack, 2'b01);
    req[0] = 1'b0;
    tick(2);
    apply_stimulus(0, 1'b1, 3'd1, 7'h70, 8'h99);
    check_output("b2b_idle_ready", data_ready, 0);
    tick(1);
    check_output("b2b_second_grant", grant, 2'b01);
    check_output("b2b_latch_ready", data_ready, 0);
    tick(1);
    check_output("b2b_second_ready", data_ready, 1);
    check_output("b2b_second_data", out_data, 8'h99);
    tick(5);
    check_output("b2b_second_ack", ack, 2'b01);
    req[0] = 1'b0;
    tick(2);
    check_output("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_bus_arbiter.md
Name: param_bus_arbiter

Overview:
- Shares the synth-controller parameter write bus (bank select, register address, data byte, data_ready strobe) between NUM_REQ requesters, e.g. the MIDI SysEx parser and the HPS/Avalon bridge.
- Grants one write at a time using round-robin arbitration.
- Holds data_ready high long enough for the downstream 4-stage ready pipeline and bank decoder to complete.
- Enforces a low gap between writes, and acknowledges or rejects each request.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- BANK_W, 3, bank address width
- ADR_W, 7, register address width within a bank
- DATA_W, 8, data byte width
- NUM_BANKS, 6, number of valid banks; valid bank indices are 0..NUM_BANKS-1
- HOLD_CYC, 5, cycles data_ready stays high (minimum 4)
- GAP_CYC, 2, cycles data_ready stays low between writes (minimum 1)

Ports:
- reg_clk  in  1  single clock
- reset_reg_N  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester write request; level, held until ack or err
- req_bank  in  NUM_REQ*BANK_W  packed bank index; requester i uses slice [i*BANK_W +: BANK_W]
- req_adr  in  NUM_REQ*ADR_W  packed register address
- req_data  in  NUM_REQ*DATA_W  packed data byte
- grant  out  NUM_REQ  one-hot; the current owner of the bus
- ack  out  NUM_REQ  one-cycle pulse; the write has completed
- err  out  NUM_REQ  one-cycle pulse; the request was rejected because its bank is invalid
- bank_adr  out  BANK_W  bank index driven to the bank decoder
- reg_adr  out  ADR_W  register address driven to the bus
- out_data  out  DATA_W  data byte driven to the bus
- data_ready  out  1  write strobe
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, reset_reg_N=0):
  - state=IDLE; the round-robin pointer is set so requester 0 has highest priority.
  - All outputs are 0.
  - Reset during STROBE drops data_ready immediately; the aborted write is not acked, and its requester re-arbitrates after reset.
- FSM states: IDLE, LATCH, STROBE, GAP, REJECT.
- IDLE:
  - If any req is high, select the first requester at or after the pointer in ascending index order, wrapping around.
  - Next state is LATCH.
- LATCH (1 cycle):
  - Set grant[winner]=1.
  - Register the winner's bank, address and data into bank_adr, reg_adr and out_data.
  - Sample req again in this cycle. If the winner's req is no longer high, drop grant, issue no strobe and no ack, and go to IDLE with the pointer unchanged.
  - Otherwise, if bank >= NUM_BANKS, go to REJECT; else go to STROBE.
- STROBE:
  - data_ready=1 for exactly HOLD_CYC cycles, counted by a down-counter loaded with HOLD_CYC-1.
  - bank_adr, reg_adr and out_data stay stable for the whole state.
  - Next state is GAP.
- GAP:
  - data_ready=0 for GAP_CYC cycles.
  - In the first GAP cycle: ack[winner]=1 and grant drops to 0.
  - Bus outputs hold their values until the end of GAP, then clear to 0 on entry to IDLE.
  - The pointer moves to winner+1 (mod NUM_REQ) on GAP exit.
- REJECT (1 cycle):
  - err[winner]=1, grant drops, bus outputs clear.
  - The pointer advances; next state is IDLE.
- Latency: req sampled high in IDLE at cycle n gives grant at n+1 (LATCH), data_ready high n+2..n+1+HOLD_CYC, ack at n+2+HOLD_CYC. The next grant comes no earlier than n+3+HOLD_CYC+GAP_CYC.
- Requester contract:
  - Deassert req in the cycle after ack or err is seen.
  - Inputs may change freely while not granted; they are sampled only in LATCH.
- Requests arriving while busy are held pending and are not lost.
- Only one of ack or err pulses per grant, never both.
- grant, ack and err are each at most one-hot; ack and err are never high in the same cycle.

Test Plan:
- Single request: after reset, req[0]=1, bank 2, adr 0x11, data 0x5A -> grant[0] at +1; data_ready high 5 cycles with bank_adr=2, reg_adr=0x11, out_data=0x5A stable; ack[0] pulse at +7; next possible grant no earlier than +10.
- Simultaneous requests: req=2'b11 from idle after reset -> requester 0 is served first, then requester 1; with both held, subsequent grants alternate 0,1,0,1; data_ready is low at least 2 cycles between strobes.
- Invalid bank: req[1]=1 with bank 6 -> grant[1] for 1 cycle, err[1] pulse the next cycle, no data_ready, bus returns to 0, pointer advances.
- Reset mid-strobe: assert reset_reg_N=0 on the 3rd data_ready cycle -> data_ready, grant and bus outputs go to 0 without a clock edge; no ack; after release the held req is re-served from LATCH.
- Request withdrawn: req[0] drops in the LATCH cycle -> grant drops, no strobe, no ack or err, pointer unchanged, FSM back to IDLE.
- Back-to-back: requester 0 re-asserts req 2 cycles after its ack while requester 1 is idle -> requester 0 is granted again; strobe spacing is HOLD_CYC+GAP_CYC+2 cycles or more.
